// File: rtl/btb_update_queue.sv
// Decouples resolved-branch BTB updates from the BTB write port: taken,
// unpredicted branches are queued, merged by PC at the tail, and drained in order.
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif

module btb_update_queue #(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      brres_valid,
  input  logic [`ADDR_LEN-1:0]      brres_pc,
  input  logic                      brres_taken,
  input  logic [`ADDR_LEN-1:0]      brres_target,
  input  logic                      brres_predhit,
  input  logic [`ADDR_LEN-1:0]      brres_predaddr,
  input  logic                      wr_stall,
  input  logic                      clear,
  output logic                      we,
  output logic [`ADDR_LEN-1:0]      jmpsrc,
  output logic [`ADDR_LEN-1:0]      jmpdst,
  output logic                      mispred,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic [7:0]                drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int AW    = `ADDR_LEN;

  logic [AW-1:0]    pc_mem  [DEPTH];
  logic [AW-1:0]    tgt_mem [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             we_q, we_d;
  logic [AW-1:0]    jmpsrc_q, jmpsrc_d;
  logic [AW-1:0]    jmpdst_q, jmpdst_d;
  logic             mispred_q, mispred_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic [PTR_W-1:0] newest_idx;
  logic             candidate;
  logic             is_full;
  logic             pop;
  logic             merge;
  logic             push;
  logic             drop;

  always_comb begin
    newest_idx = tail_q - PTR_W'(1);
    is_full    = (count_q == CNT_W'(DEPTH));
    candidate  = brres_valid && brres_taken &&
                 (!brres_predhit || (brres_predaddr != brres_target));
    pop        = (count_q != '0) && !wr_stall && !clear;
    // The newest entry can only absorb a merge if it is not leaving the queue now.
    merge      = candidate && !clear && (count_q != '0) &&
                 (pc_mem[newest_idx] == brres_pc) &&
                 !(pop && (count_q == CNT_W'(1)));
    push       = candidate && !clear && !merge && (!is_full || pop);
    drop       = candidate && !merge && is_full && !pop;
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    we_d       = pop;
    jmpsrc_d   = jmpsrc_q;
    jmpdst_d   = jmpdst_q;
    mispred_d  = brres_valid &&
                 ((brres_taken != brres_predhit) ||
                  (brres_taken && brres_predhit && (brres_predaddr != brres_target)));
    drop_cnt_d = drop_cnt_q;

    if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end

    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop) begin
        jmpsrc_d = pc_mem[head_q];
        jmpdst_d = tgt_mem[head_q];
        head_d   = head_q + PTR_W'(1);
      end
      if (push) begin
        tail_d = tail_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage holds no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_q]  <= brres_pc;
      tgt_mem[tail_q] <= brres_target;
    end else if (merge) begin
      tgt_mem[newest_idx] <= brres_target;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      we_q       <= 1'b0;
      jmpsrc_q   <= '0;
      jmpdst_q   <= '0;
      mispred_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      we_q       <= we_d;
      jmpsrc_q   <= jmpsrc_d;
      jmpdst_q   <= jmpdst_d;
      mispred_q  <= mispred_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign we       = we_q;
  assign jmpsrc   = jmpsrc_q;
  assign jmpdst   = jmpdst_q;
  assign mispred  = mispred_q;
  assign count    = count_q;
  assign full     = is_full;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: doc/btb_update_queue.md
BTB_UPDATE_QUEUE -- requirements
Module: btb_update_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the queue entry count (power of two, at least 2).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, asynchronous, active-low reset.
REQ-004 SHALL have port brres_valid, input, 1 bit, a resolved branch is presented this cycle.
REQ-005 SHALL have port brres_pc, input, `ADDR_LEN bits, the branch source address.
REQ-006 SHALL have port brres_taken, input, 1 bit, the resolved direction.
REQ-007 SHALL have port brres_target, input, `ADDR_LEN bits, the resolved target.
REQ-008 SHALL have port brres_predhit, input, 1 bit, the BTB hit recorded at fetch.
REQ-009 SHALL have port brres_predaddr, input, `ADDR_LEN bits, the BTB jmpaddr recorded at fetch.
REQ-010 SHALL have port wr_stall, input, 1 bit, BTB write port unavailable this cycle.
REQ-011 SHALL have port clear, input, 1 bit, synchronous queue discard.
REQ-012 SHALL have port we, output, 1 bit, registered BTB write strobe.
REQ-013 SHALL have ports jmpsrc and jmpdst, output, `ADDR_LEN bits each, registered BTB write source and destination.
REQ-014 SHALL have port mispred, output, 1 bit, registered misprediction flag.
REQ-015 SHALL have port count, output, log2(DEPTH)+1 bits, current occupancy.
REQ-016 SHALL have port full, output, 1 bit, count == DEPTH.
REQ-017 SHALL have port drop_cnt, output, 8 bits, the number of candidates dropped.

Function
REQ-018 SHALL form candidate = brres_valid & brres_taken & (~brres_predhit | brres_predaddr != brres_target).
REQ-019 SHALL set mispred at the next edge to brres_valid & ((brres_taken != brres_predhit) | (brres_taken & brres_predhit & brres_predaddr != brres_target)), and clear it otherwise; mispred is a one-cycle pulse per offending branch.
REQ-020 SHALL push a candidate's {pc, target} into the FIFO tail at the rising edge of its cycle.
REQ-021 SHALL merge instead of push when count > 0, the newest queued entry has pc == brres_pc, and that entry is not being popped this cycle; the merge overwrites that entry's target and leaves count unchanged.
REQ-022 SHALL pop the head at an edge when count > 0, wr_stall == 0 and clear == 0, and SHALL load the head into jmpsrc/jmpdst with we = 1 for the following cycle.
REQ-023 SHALL drive we = 0 in every cycle that follows an edge with no pop; jmpsrc/jmpdst hold their last values.
REQ-024 SHALL give an accepted candidate a minimum latency of two edges to we (push at edge N, pop at edge N+1, we high during cycle N+1..N+2).
REQ-025 SHALL accept a push when full only if a pop occurs at the same edge; otherwise it SHALL drop the candidate and increment drop_cnt, which saturates at 255.
REQ-026 SHALL, on a simultaneous push and pop at count 0, never bypass: the push is stored and count becomes 1.
REQ-027 SHALL wrap head and tail pointers modulo DEPTH with no gap or duplicate entry.
REQ-028 SHALL, when clear == 1, set count = 0, reset the pointers, ignore any push and pop that cycle, and drive we = 0 next cycle; mispred and drop_cnt still update normally.
REQ-029 SHALL never issue a pop of stale data: entries are only written by push or merge.

Reset
REQ-030 SHALL, when reset == 0, immediately (asynchronously) force we = 0, mispred = 0, count = 0, full = 0, drop_cnt = 0, jmpsrc = 0, jmpdst = 0 and the pointers to 0.
REQ-031 SHALL discard queued entries on a mid-operation reset and SHALL take no push or pop on the first edge after reset release unless the inputs request one.

Verification
REQ-032 SHALL be verified with: a single taken branch pc=0x100, target=0x200, predhit=0 -> mispred=1 after edge 1; we=1, jmpsrc=0x100, jmpdst=0x200 after edge 2; count back to 0.
REQ-033 SHALL be verified with: a taken branch, predhit=1, predaddr == target -> no push, mispred=0; and a not-taken branch with predhit=1 -> mispred=1 and no push.
REQ-034 SHALL be verified with: wr_stall=1 and 5 distinct candidates at DEPTH=4 -> full=1, drop_cnt=1; release stall -> 4 writes in FIFO order on consecutive cycles.
REQ-035 SHALL be verified with: back-to-back candidates at pc=0x40 with targets 0x80 then 0xC0 under stall -> count=1; after release a single write with jmpdst=0xC0.
REQ-036 SHALL be verified with: a full queue receiving a simultaneous push and pop -> count stays 4, drop_cnt unchanged; clear with 3 entries -> count=0 and we=0 next cycle.
REQ-037 SHALL be verified with: reset asserted mid-drain -> we=0 and count=0 without a clock edge; resume produces no stale write.
